multicycle_ctrl_fsm: RTL and testbench

Multi-cycle sequencer for the single-issue MIPS-subset CPU. It replaces the single-cycle opcode decoder with a Moore/Mealy state machine. Each instruction is split into IF / ID / EXE / MEM / WB cycles. The block drives the same datapath control signals, plus the instruction-register write enable and a data-memory ready handshake, so one ALU and one memory port are reused across cycles.

---
 rtl/cpu_ctrl_pkg.sv | 52 +++++
 rtl/ctrl_opcode_decode.sv | 39 +++
 rtl/multicycle_ctrl_fsm.sv | 121 ++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants for the multi-cycle control sequencer:
// opcodes, FSM state encodings, ALU functions and decode bundle.
package cpu_ctrl_pkg;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  typedef enum logic [3:0] {
    S_IF      = 4'd0,
    S_ID      = 4'd1,
    S_EXE_ALU = 4'd2,
    S_EXE_MEM = 4'd3,
    S_EXE_BR  = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_ALU  = 4'd7,
    S_WB_LD   = 4'd8,
    S_HALT    = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU  = 3'd0,
    CLS_LD   = 3'd1,
    CLS_ST   = 3'd2,
    CLS_BR   = 3'd3,
    CLS_HALT = 3'd4,
    CLS_ILL  = 3'd5
  } cls_e;

  typedef struct packed {
    cls_e       cls;
    logic [2:0] aluop;
    logic       srcb;
    logic       ext;
    logic       regout;
  } dec_t;

endpackage

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode decoder: instruction class plus the
// per-instruction static datapath fields.
module ctrl_opcode_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  output dec_t       dec_o
);

  always_comb begin
    dec_o = '{cls: CLS_ILL, aluop: ALU_ADD,
              srcb: 1'b0, ext: 1'b0, regout: 1'b0};
    unique case (1'b1)
      (opcode_i == OP_ADD),
      (opcode_i == OP_MOVE):
        dec_o = '{CLS_ALU, ALU_ADD, 1'b0, 1'b0, 1'b1};
      (opcode_i == OP_SUB):
        dec_o = '{CLS_ALU, ALU_SUB, 1'b0, 1'b0, 1'b1};
      (opcode_i == OP_AND):
        dec_o = '{CLS_ALU, ALU_AND, 1'b0, 1'b0, 1'b1};
      (opcode_i == OP_OR):
        dec_o = '{CLS_ALU, ALU_OR, 1'b0, 1'b0, 1'b1};
      (opcode_i == OP_ADDI):
        dec_o = '{CLS_ALU, ALU_ADD, 1'b1, 1'b1, 1'b0};
      (opcode_i == OP_ORI):
        dec_o = '{CLS_ALU, ALU_OR, 1'b1, 1'b0, 1'b0};
      (opcode_i == OP_LW):
        dec_o = '{CLS_LD, ALU_ADD, 1'b1, 1'b1, 1'b0};
      (opcode_i == OP_SW):
        dec_o = '{CLS_ST, ALU_ADD, 1'b1, 1'b1, 1'b0};
      (opcode_i == OP_BEQ):
        dec_o = '{CLS_BR, ALU_SUB, 1'b0, 1'b1, 1'b0};
      (opcode_i == OP_HALT):
        dec_o = '{CLS_HALT, ALU_ADD, 1'b0, 1'b0, 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle IF/ID/EXE/MEM/WB sequencer driving the shared
// ALU / memory-port datapath controls.
module multicycle_ctrl_fsm
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       Zero,
  input  logic       dmem_ready,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic       ALUSrcB,
  output logic [2:0] ALUOp,
  output logic       ALUM2Reg,
  output logic       RegOut,
  output logic       DataMemRW,
  output logic       DataMemEn,
  output logic       PCSrc,
  output logic       ExtSel,
  output logic       retire,
  output logic       halted,
  output logic [3:0] state
);

  state_e state_q, state_d;
  dec_t   dec;

  ctrl_opcode_decode u_dec (
    .opcode_i (opcode),
    .dec_o    (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    PCWre     = 1'b0;
    IRWre     = 1'b0;
    InsMemRW  = 1'b0;
    RegWre    = 1'b0;
    ALUSrcB   = 1'b0;
    ALUOp     = ALU_ADD;
    ALUM2Reg  = 1'b0;
    RegOut    = 1'b0;
    DataMemRW = 1'b0;
    DataMemEn = 1'b0;
    PCSrc     = 1'b0;
    ExtSel    = 1'b0;
    // Opcode is only meaningful once the IR holds it.
    if (state_q != S_IF && state_q != S_HALT) begin
      ALUOp   = dec.aluop;
      ALUSrcB = dec.srcb;
      ExtSel  = dec.ext;
      RegOut  = dec.regout;
    end
    unique case (state_q)
      S_IF: begin
        IRWre    = 1'b1;
        InsMemRW = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        unique case (dec.cls)
          CLS_ALU:         state_d = S_EXE_ALU;
          CLS_LD, CLS_ST:  state_d = S_EXE_MEM;
          CLS_BR:          state_d = S_EXE_BR;
          CLS_HALT:        state_d = S_HALT;
          default: begin
            state_d = S_IF;
            PCWre   = 1'b1;
          end
        endcase
      end
      S_EXE_ALU: state_d = S_WB_ALU;
      S_EXE_MEM: begin
        state_d = (dec.cls == CLS_LD) ? S_MEM_RD : S_MEM_WR;
      end
      S_EXE_BR: begin
        PCWre   = 1'b1;
        PCSrc   = Zero;
        state_d = S_IF;
      end
      S_MEM_RD: begin
        DataMemEn = 1'b1;
        if (dmem_ready) state_d = S_WB_LD;
      end
      S_MEM_WR: begin
        DataMemEn = 1'b1;
        DataMemRW = 1'b1;
        if (dmem_ready) begin
          PCWre   = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB_ALU: begin
        RegWre  = 1'b1;
        PCWre   = 1'b1;
        state_d = S_IF;
      end
      S_WB_LD: begin
        RegWre   = 1'b1;
        ALUM2Reg = 1'b1;
        PCWre    = 1'b1;
        state_d  = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  assign retire = PCWre;
  assign halted = (state_q == S_HALT);
  assign state  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm against a
// per-instruction phase-list reference model.
module tb_multicycle_ctrl_fsm;
  import cpu_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       Zero, dmem_ready;
  logic       PCWre, IRWre, InsMemRW, RegWre, ALUSrcB;
  logic [2:0] ALUOp;
  logic       ALUM2Reg, RegOut, DataMemRW, DataMemEn;
  logic       PCSrc, ExtSel, retire, halted;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .Zero       (Zero),
    .dmem_ready (dmem_ready),
    .PCWre      (PCWre),
    .IRWre      (IRWre),
    .InsMemRW   (InsMemRW),
    .RegWre     (RegWre),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .ALUM2Reg   (ALUM2Reg),
    .RegOut     (RegOut),
    .DataMemRW  (DataMemRW),
    .DataMemEn  (DataMemEn),
    .PCSrc      (PCSrc),
    .ExtSel     (ExtSel),
    .retire     (retire),
    .halted     (halted),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ctl();
    return {PCWre, IRWre, InsMemRW, RegWre, ALUSrcB, ALUOp,
            ALUM2Reg, RegOut, DataMemRW, DataMemEn, PCSrc,
            ExtSel, retire, halted};
  endfunction

  // 0 alu, 1 load, 2 store, 3 branch, 4 halt, 5 illegal
  function automatic int kind(input logic [5:0] op);
    case (op)
      6'b000000, 6'b000001, 6'b000010, 6'b010000,
      6'b010001, 6'b010010, 6'b100000: return 0;
      6'b100111: return 1;
      6'b100110: return 2;
      6'b110000: return 3;
      6'b111111: return 4;
      default:   return 5;
    endcase
  endfunction

  // {ALUOp, ALUSrcB, ExtSel, RegOut}
  function automatic logic [5:0] fields(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100000: return 6'b000_0_0_1;
      6'b000010:            return 6'b001_0_0_1;
      6'b010001:            return 6'b100_0_0_1;
      6'b010010:            return 6'b011_0_0_1;
      6'b000001:            return 6'b000_1_1_0;
      6'b010000:            return 6'b011_1_0_0;
      6'b100111, 6'b100110: return 6'b000_1_1_0;
      6'b110000:            return 6'b001_0_1_0;
      default:              return 6'b000_0_0_0;
    endcase
  endfunction

  function automatic logic [15:0] exp_cycle(
    input state_e ph, input logic [5:0] op,
    input logic last, input logic zv);
    logic [5:0] f;
    logic pcw, irw, regw, m2r, memrw, memen, pcsrc, hlt;
    f = (ph == S_IF || ph == S_HALT) ? 6'd0 : fields(op);
    {pcw, irw, regw, m2r, memrw, memen, pcsrc, hlt} = '0;
    case (ph)
      S_IF:     irw = 1'b1;
      S_ID:     pcw = (kind(op) == 5);
      S_WB_ALU: begin regw = 1'b1; pcw = 1'b1; end
      S_WB_LD:  begin regw = 1'b1; m2r = 1'b1; pcw = 1'b1; end
      S_MEM_RD: memen = 1'b1;
      S_MEM_WR: begin memen = 1'b1; memrw = 1'b1; pcw = last; end
      S_EXE_BR: begin pcw = 1'b1; pcsrc = zv; end
      S_HALT:   hlt = 1'b1;
      default:  ;
    endcase
    return {pcw, irw, irw, regw, f[2], f[5:3], m2r, f[0],
            memrw, memen, pcsrc, f[1], pcw, hlt};
  endfunction

  task automatic step(input state_e ph, input logic [5:0] op,
                      input logic last, input logic zv,
                      input logic dr);
    @(negedge clk);
    opcode     = op;
    Zero       = zv;
    dmem_ready = dr;
    #1;
    chk($sformatf("%s/state", ph.name()), 32'(state), 32'(ph));
    chk($sformatf("%s/ctl op=%b", ph.name(), op),
        32'(ctl()), 32'(exp_cycle(ph, op, last, zv)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst/state", 32'(state), 32'(S_IF));
    chk("rst/ctl", 32'(ctl()), 32'(exp_cycle(S_IF, opcode, 0, 0)));
    @(posedge clk);
    #1;
    chk("rst_hold/state", 32'(state), 32'(S_IF));
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int waits,
                           input logic zv);
    logic r;
    r = 1'($urandom);
    step(S_IF, op, 0, zv, r);
    step(S_ID, op, 0, zv, 1'($urandom));
    case (kind(op))
      0: begin
        step(S_EXE_ALU, op, 0, zv, 1'($urandom));
        step(S_WB_ALU, op, 0, zv, 1'($urandom));
      end
      1: begin
        step(S_EXE_MEM, op, 0, zv, 1'($urandom));
        for (int i = 0; i < waits; i++)
          step(S_MEM_RD, op, 0, zv, 1'b0);
        step(S_MEM_RD, op, 1, zv, 1'b1);
        step(S_WB_LD, op, 0, zv, 1'($urandom));
      end
      2: begin
        step(S_EXE_MEM, op, 0, zv, 1'($urandom));
        for (int i = 0; i < waits; i++)
          step(S_MEM_WR, op, 0, zv, 1'b0);
        step(S_MEM_WR, op, 1, zv, 1'b1);
      end
      3: step(S_EXE_BR, op, 0, zv, 1'($urandom));
      4: begin
        for (int i = 0; i < 20; i++)
          step(S_HALT, op, 0, 1'($urandom), 1'($urandom));
      end
      default: ;
    endcase
  endtask

  logic [5:0] ops [10] = '{6'b000000, 6'b000001, 6'b000010,
                           6'b010000, 6'b010001, 6'b010010,
                           6'b100000, 6'b100110, 6'b100111,
                           6'b110000};

  initial begin
    logic [5:0] op;
    rst_n      = 1'b0;
    opcode     = 6'b000000;
    Zero       = 1'b0;
    dmem_ready = 1'b0;
    #1;
    chk("por/state", 32'(state), 32'(S_IF));
    chk("por/ctl", 32'(ctl()), 32'(16'h6000));
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_instr(6'b000000, 0, 1'b0);
    run_instr(6'b100111, 2, 1'b0);
    run_instr(6'b100110, 0, 1'b1);
    run_instr(6'b110000, 0, 1'b1);
    run_instr(6'b110000, 0, 1'b0);
    run_instr(6'b101010, 0, 1'b0);

    // Abort a store while it waits on the memory port.
    step(S_IF, 6'b100110, 0, 0, 1'b1);
    step(S_ID, 6'b100110, 0, 0, 1'b1);
    step(S_EXE_MEM, 6'b100110, 0, 0, 1'b1);
    step(S_MEM_WR, 6'b100110, 0, 0, 1'b0);
    do_reset();
    run_instr(6'b000000, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      int idx;
      idx = $urandom_range(0, 10);
      if (idx == 10) begin
        op = 6'($urandom);
        if (kind(op) == 4) op = 6'b101010;
      end else begin
        op = ops[idx];
      end
      run_instr(op, $urandom_range(0, 3), 1'($urandom));
    end

    run_instr(6'b111111, 0, 1'b0);
    do_reset();
    run_instr(6'b000010, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
